// File: rtl/mul_issue_sched.sv
// Issue scheduler for a single non-pipelined multiply/divide unit.
// It picks a ready reservation-station entry round-robin, times the op, and then arbitrates for the CDB.
module mul_issue_sched #(
    parameter int NUM_RS  = 3,
    parameter int TAG_W   = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic [NUM_RS-1:0]     rs_valid,
    input  logic [NUM_RS-1:0]     rs_ready,
    input  logic [3*NUM_RS-1:0]   rs_fun3,
    input  logic [TAG_W*NUM_RS-1:0] rs_tag,
    input  logic                  flush,
    input  logic                  cdb_gnt,
    output logic                  issue_valid,
    output logic [1:0]            issue_sel,
    output logic [2:0]            issue_fun3,
    output logic [TAG_W-1:0]      issue_tag,
    output logic                  unit_busy,
    output logic                  cdb_req,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [NUM_RS-1:0]     rs_free
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        REQ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic                  issue_valid_q, issue_valid_d;
    logic [1:0]            issue_sel_q, issue_sel_d;
    logic [2:0]            issue_fun3_q, issue_fun3_d;
    logic [TAG_W-1:0]      issue_tag_q, issue_tag_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [NUM_RS-1:0]     rs_free_q, rs_free_d;

    logic [NUM_RS-1:0]     cand_s;
    logic                  found_s;
    logic [1:0]            win_s;
    logic [2:0]            win_fun3_s;
    logic [TAG_W-1:0]      win_tag_s;

    // Round-robin pick: first pass covers entries at or above rr_ptr, second pass wraps to the low entries.
    always_comb begin
        cand_s     = rs_valid & rs_ready & ~rs_free_q;
        found_s    = 1'b0;
        win_s      = 2'd0;
        win_fun3_s = 3'd0;
        win_tag_s  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (!found_s && cand_s[i] && (2'(i) >= rr_ptr_q)) begin
                found_s    = 1'b1;
                win_s      = 2'(i);
                win_fun3_s = rs_fun3[3*i +: 3];
                win_tag_s  = rs_tag[TAG_W*i +: TAG_W];
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (!found_s && cand_s[i]) begin
                found_s    = 1'b1;
                win_s      = 2'(i);
                win_fun3_s = rs_fun3[3*i +: 3];
                win_tag_s  = rs_tag[TAG_W*i +: TAG_W];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic; flush wins over both a pending grant and a new issue.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        issue_valid_d = 1'b0;
        issue_sel_d   = issue_sel_q;
        issue_fun3_d  = issue_fun3_q;
        issue_tag_d   = issue_tag_q;
        cdb_valid_d   = 1'b0;
        rs_free_d     = '0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        issue_valid_d = 1'b1;
                        issue_sel_d   = win_s;
                        issue_fun3_d  = win_fun3_s;
                        issue_tag_d   = win_tag_s;
                        rr_ptr_d      = (win_s == 2'(NUM_RS-1)) ? 2'd0 : win_s + 2'd1;
                        cnt_d         = (win_fun3_s == 3'd1) ? CNT_W'(DIV_LAT-1) : CNT_W'(MUL_LAT-1);
                        state_d       = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        state_d = REQ;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                REQ: begin
                    if (cdb_gnt) begin
                        cdb_valid_d = 1'b1;
                        rs_free_d   = {{(NUM_RS-1){1'b0}}, 1'b1} << issue_sel_q;
                        state_d     = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= 2'd0;
            issue_valid_q <= 1'b0;
            issue_sel_q   <= 2'd0;
            issue_fun3_q  <= 3'd0;
            issue_tag_q   <= '0;
            cdb_valid_q   <= 1'b0;
            rs_free_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_sel_q   <= issue_sel_d;
            issue_fun3_q  <= issue_fun3_d;
            issue_tag_q   <= issue_tag_d;
            cdb_valid_q   <= cdb_valid_d;
            rs_free_q     <= rs_free_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_sel   = issue_sel_q;
    assign issue_fun3  = issue_fun3_q;
    assign issue_tag   = issue_tag_q;
    assign unit_busy   = (state_q != IDLE);
    assign cdb_req     = (state_q == REQ);
    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = issue_tag_q;
    assign rs_free     = rs_free_q;

endmodule

// File: tb/tb_mul_issue_sched.sv
// Directed bench for mul_issue_sched: round-robin, multiply, divide with late grant, flush and async reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_mul_issue_sched;

    logic       clk1;
    logic       rst_n;
    logic [2:0] rs_valid;
    logic [2:0] rs_ready;
    logic [8:0] rs_fun3;
    logic [8:0] rs_tag;
    logic       flush;
    logic       cdb_gnt;
    logic       issue_valid;
    logic [1:0] issue_sel;
    logic [2:0] issue_fun3;
    logic [2:0] issue_tag;
    logic       unit_busy;
    logic       cdb_req;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [2:0] rs_free;

    int n_tests = 0;
    int n_fail  = 0;

    mul_issue_sched #(.NUM_RS(3), .TAG_W(3), .MUL_LAT(4), .DIV_LAT(16)) dut (
        .clk1(clk1), .rst_n(rst_n), .rs_valid(rs_valid), .rs_ready(rs_ready),
        .rs_fun3(rs_fun3), .rs_tag(rs_tag), .flush(flush), .cdb_gnt(cdb_gnt),
        .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_fun3(issue_fun3),
        .issue_tag(issue_tag), .unit_busy(unit_busy), .cdb_req(cdb_req),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rs_free(rs_free)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk1);
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, issue_valid, issue_sel, issue_fun3, issue_tag, unit_busy,
                cdb_req, cdb_valid, cdb_tag, rs_free};
    endfunction

    initial begin
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;
        rst_n = 1'b0; rs_valid = 3'b000; rs_ready = 3'b000; rs_fun3 = 9'd0;
        rs_tag = 9'd0; flush = 1'b0; cdb_gnt = 1'b0;

        // Reset state
        step();
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // Round-robin: all ready, grant high, tags 1/2/3, issue at first edge after release
        rs_valid = 3'b111; rs_ready = 3'b111;
        rs_tag = {3'd3, 3'd2, 3'd1}; cdb_gnt = 1'b1;
        step();
        chk("rr_issue0_valid", {31'd0, issue_valid}, 32'd1);
        chk("rr_issue0_sel", {30'd0, issue_sel}, 32'd0);
        chk("rr_issue0_tag", {29'd0, issue_tag}, 32'd1);
        for (int r = 1; r < 4; r++) begin
            repeat (5) step();
            chk("rr_free_cycle_no_issue", {31'd0, issue_valid}, 32'd0);
            chk("rr_free_onehot", {29'd0, rs_free}, 32'd1 << rr_exp[r-1]);
            step();
            chk("rr_issue_valid", {31'd0, issue_valid}, 32'd1);
            chk("rr_issue_sel", {30'd0, issue_sel}, {30'd0, rr_exp[r]});
        end
        rs_valid = 3'b000; rs_ready = 3'b000;
        repeat (4) step();
        chk("rr_last_req", {31'd0, cdb_req}, 32'd1);
        step();
        chk("rr_last_cdb_valid", {31'd0, cdb_valid}, 32'd1);
        chk("rr_last_cdb_tag", {29'd0, cdb_tag}, 32'd1);
        chk("rr_last_free", {29'd0, rs_free}, 32'b001);
        step();

        // Single multiply on entry 0 (tag 5); rs_valid[0] held to check freed-entry masking
        rs_valid = 3'b001; rs_ready = 3'b001; rs_tag = {3'd3, 3'd2, 3'd5};
        step();
        chk("mul_issue_valid", {31'd0, issue_valid}, 32'd1);
        chk("mul_issue_sel", {30'd0, issue_sel}, 32'd0);
        chk("mul_issue_fun3", {29'd0, issue_fun3}, 32'd0);
        chk("mul_issue_tag", {29'd0, issue_tag}, 32'd5);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("mul_no_early_req", {30'd0, unit_busy, cdb_req}, 32'b10);
        end
        step();
        chk("mul_req_n4", {31'd0, cdb_req}, 32'd1);
        chk("mul_req_tag", {29'd0, cdb_tag}, 32'd5);
        step();
        chk("mul_cdb_valid_n5", {31'd0, cdb_valid}, 32'd1);
        chk("mul_cdb_tag_n5", {29'd0, cdb_tag}, 32'd5);
        chk("mul_free_n5", {29'd0, rs_free}, 32'b001);
        chk("mul_idle_n5", {30'd0, unit_busy, cdb_req}, 32'd0);
        step();
        chk("mask_no_reissue", {31'd0, issue_valid}, 32'd0);
        chk("mask_free_pulse_end", {29'd0, rs_free}, 32'd0);

        // Divide on entry 1 (tag 2), grant three cycles after the request; entry drops after issue
        rs_valid = 3'b010; rs_ready = 3'b010; rs_fun3 = 9'b000_001_000; cdb_gnt = 1'b0;
        step();
        chk("div_issue_sel", {30'd0, issue_sel}, 32'd1);
        chk("div_issue_fun3", {29'd0, issue_fun3}, 32'd1);
        chk("div_issue_tag", {29'd0, issue_tag}, 32'd2);
        rs_valid = 3'b000; rs_ready = 3'b000;
        for (int k = 1; k < 16; k++) begin
            step();
            chk("div_exec_busy_no_req", {30'd0, unit_busy, cdb_req}, 32'b10);
        end
        for (int k = 16; k < 19; k++) begin
            step();
            chk("div_req_held", {30'd0, unit_busy, cdb_req}, 32'b11);
            chk("div_no_early_valid", {31'd0, cdb_valid}, 32'd0);
        end
        cdb_gnt = 1'b1;
        step();
        chk("div_cdb_valid_n19", {31'd0, cdb_valid}, 32'd1);
        chk("div_cdb_tag", {29'd0, cdb_tag}, 32'd2);
        chk("div_free", {29'd0, rs_free}, 32'b010);

        // Flush in EXEC: entry 0 issues from rr_ptr=2, flush during N+2, then rr_ptr=1 picks entry 1
        rs_fun3 = 9'd0; rs_tag = {3'd3, 3'd4, 3'd6};
        rs_valid = 3'b001; rs_ready = 3'b001;
        step();
        chk("flush_issue_sel", {30'd0, issue_sel}, 32'd0);
        chk("flush_issue_tag", {29'd0, issue_tag}, 32'd6);
        step();
        step();
        flush = 1'b1;
        step();
        chk("flush_idle", {31'd0, unit_busy}, 32'd0);
        chk("flush_quiet", {28'd0, cdb_req, cdb_valid, issue_valid, |rs_free}, 32'd0);
        flush = 1'b0; rs_valid = 3'b111; rs_ready = 3'b111;
        step();
        chk("flush_next_valid", {31'd0, issue_valid}, 32'd1);
        chk("flush_next_sel_rrptr", {30'd0, issue_sel}, 32'd1);
        chk("flush_next_tag", {29'd0, issue_tag}, 32'd4);
        rs_valid = 3'b000; rs_ready = 3'b000;
        repeat (4) step();
        chk("flush_next_req", {31'd0, cdb_req}, 32'd1);
        step();
        chk("flush_next_cdb", {28'd0, cdb_valid, rs_free}, 32'b1010);

        // Async reset mid-REQ, released before the next edge with entry 2 ready
        rs_valid = 3'b001; rs_ready = 3'b001; cdb_gnt = 1'b0;
        step();
        chk("rst_pre_issue_sel", {30'd0, issue_sel}, 32'd0);
        repeat (4) step();
        chk("rst_pre_req", {31'd0, cdb_req}, 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 32'd0);
        rs_valid = 3'b100; rs_ready = 3'b100;
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_first_edge_valid", {31'd0, issue_valid}, 32'd1);
        chk("rst_first_edge_sel", {30'd0, issue_sel}, 32'd2);
        chk("rst_first_edge_tag", {29'd0, issue_tag}, 32'd3);
        chk("rst_no_stale_cdb", {28'd0, cdb_valid, rs_free}, 32'd0);
        rs_valid = 3'b000; rs_ready = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
